// File: rtl/hyperbus_pkg.sv
// Shared types for the hyperbus transaction shaper: CA word, piece record and CA packing.
package hyperbus_pkg;

  localparam int unsigned PieceLenWidth = 16;
  localparam int unsigned PieceCsWidth  = 1;

  localparam logic CaMemSpace = 1'b0;
  localparam logic CaLinear   = 1'b1;

  typedef logic [47:0] hyper_ca_t;

  typedef struct packed {
    hyper_ca_t                 ca;
    logic [PieceCsWidth-1:0]   cs;
    logic [PieceLenWidth-1:0]  len;
    logic                      write;
    logic                      last;
    logic                      err;
  } hyper_piece_t;

  // word_addr is the chip-local 16-bit word address.
  function automatic hyper_ca_t pack_ca(input logic write, input logic [31:0] word_addr);
    return {~write, CaMemSpace, CaLinear, word_addr[31:3], 13'b0, word_addr[2:0]};
  endfunction

endpackage

// File: rtl/hyperbus_burst_split.sv
// Cuts linear word transfers into pieces bounded by max burst and chip boundaries.
// Optional HYPERBUS_SPLIT_STATS_EN adds piece/split counters.
module hyperbus_burst_split
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned ChipBytes = 32'h0080_0000,
  localparam int unsigned CsWidth  = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic [LenWidth-1:0]  in_len_i,
  input  logic                 in_write_i,
  input  logic [LenWidth-1:0]  max_burst_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [47:0]          out_ca_o,
  output logic [CsWidth-1:0]   out_cs_o,
  output logic [LenWidth-1:0]  out_len_o,
  output logic                 out_write_o,
  output logic                 out_last_o,
  output logic                 out_err_o
`ifdef HYPERBUS_SPLIT_STATS_EN
  ,
  output logic [31:0]          stat_pieces_o,
  output logic [31:0]          stat_splits_o
`endif
);

  localparam int unsigned WAddrWidth   = AddrWidth - 1;
  localparam int unsigned ChipWords    = ChipBytes / 2;
  localparam int unsigned ChipWordBits = $clog2(ChipWords);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                  state_q, state_d;
  logic [WAddrWidth-1:0]   waddr_q, waddr_d, src_waddr;
  logic [LenWidth:0]       rem_q, rem_d, src_rem, cur_chunk, chunk, burst_lim;
  logic                    src_write;
  hyper_piece_t            piece_q, piece_d;
  logic                    load, hs;

  logic [WAddrWidth-ChipWordBits-1:0] chip_idx;
  logic [ChipWordBits-1:0]            local_waddr;
  logic [ChipWordBits:0]              to_bound;
  logic                               chip_err;
  logic                               unused_addr_lsb;

  assign unused_addr_lsb = in_addr_i[0];
  assign hs              = (state_q == StEmit) && out_ready_i;
  assign cur_chunk       = (LenWidth+1)'(piece_q.len) + (LenWidth+1)'(1);

  // Source of the next piece: a fresh request in idle, else the remainder after this piece.
  always_comb begin
    if (state_q == StIdle) begin
      src_waddr = in_addr_i[AddrWidth-1:1];
      src_rem   = (LenWidth+1)'(in_len_i) + (LenWidth+1)'(1);
      src_write = in_write_i;
    end else begin
      src_waddr = waddr_q + WAddrWidth'(cur_chunk);
      src_rem   = rem_q - cur_chunk;
      src_write = piece_q.write;
    end
  end

  always_comb begin
    local_waddr = src_waddr[ChipWordBits-1:0];
    chip_idx    = src_waddr[WAddrWidth-1:ChipWordBits];
    to_bound    = (ChipWordBits+1)'(ChipWords) - {1'b0, local_waddr};
    burst_lim   = {1'b0, max_burst_i} + (LenWidth+1)'(1);
    chip_err    = 32'(chip_idx) >= NumChips;

    chunk = src_rem;
    if (burst_lim < chunk) chunk = burst_lim;
    if (32'(to_bound) < 32'(chunk)) chunk = (LenWidth+1)'(to_bound);
    if (chip_err) chunk = src_rem;

    piece_d.ca    = pack_ca(src_write, 32'(local_waddr));
    piece_d.cs    = chip_err ? '0 : PieceCsWidth'(chip_idx);
    piece_d.len   = PieceLenWidth'(chunk - (LenWidth+1)'(1));
    piece_d.write = src_write;
    piece_d.last  = chip_err || (chunk == src_rem);
    piece_d.err   = chip_err;
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    rem_d   = rem_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          load    = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (hs) begin
          if (piece_q.last) begin
            state_d = StIdle;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      waddr_d = src_waddr;
      rem_d   = src_rem;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      waddr_q <= '0;
      rem_q   <= '0;
      piece_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      rem_q   <= rem_d;
      if (load) piece_q <= piece_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StEmit);
  assign out_ca_o    = piece_q.ca;
  assign out_cs_o    = CsWidth'(piece_q.cs);
  assign out_len_o   = LenWidth'(piece_q.len);
  assign out_write_o = piece_q.write;
  assign out_last_o  = piece_q.last;
  assign out_err_o   = piece_q.err;

`ifdef HYPERBUS_SPLIT_STATS_EN
  logic [31:0] pieces_q, splits_q;
  logic        first_q;

  // A transfer counts as split when its first piece is not its last.
  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pieces_q <= '0;
      splits_q <= '0;
      first_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && in_valid_i) begin
        first_q <= 1'b1;
      end else if (hs) begin
        first_q <= 1'b0;
      end
      if (hs) begin
        pieces_q <= pieces_q + 32'd1;
        if (first_q && !piece_q.last) splits_q <= splits_q + 32'd1;
      end
    end
  end

  assign stat_pieces_o = pieces_q;
  assign stat_splits_o = splits_q;
`endif

endmodule

// File: tb/tb_hyperbus_burst_split.sv
// Directed bench for hyperbus_burst_split with an arithmetic piece model and per-cycle compare.
module tb_hyperbus_burst_split;

  localparam longint ChipWords = 64'h40_0000;

  typedef struct {
    logic [47:0] ca;
    logic        cs;
    logic [15:0] len;
    logic        wr;
    logic        last;
    logic        err;
  } piece_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [15:0] in_len = '0;
  logic        in_write = 1'b0;
  logic [15:0] mb = 16'hFFFF;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_ca;
  logic        out_cs;
  logic [15:0] out_len;
  logic        out_write, out_last, out_err;
`ifdef HYPERBUS_SPLIT_STATS_EN
  logic [31:0] stat_pieces, stat_splits;
`endif

  int n_checks = 0;
  int n_err = 0;
  piece_t exp_q[$];

  always #5 clk = ~clk;

  hyperbus_burst_split dut (
    .clk_sys_i  (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_addr_i  (in_addr),
    .in_len_i   (in_len),
    .in_write_i (in_write),
    .max_burst_i(mb),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_ca_o   (out_ca),
    .out_cs_o   (out_cs),
    .out_len_o  (out_len),
    .out_write_o(out_write),
    .out_last_o (out_last),
    .out_err_o  (out_err)
`ifdef HYPERBUS_SPLIT_STATS_EN
    ,
    .stat_pieces_o(stat_pieces),
    .stat_splits_o(stat_splits)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Expected pieces from the splitting rules, in plain word arithmetic.
  function automatic void model(input logic [31:0] addr, input logic [15:0] len,
                                input logic wr, input logic [15:0] maxb);
    longint w, r, chunk, a, bnd;
    piece_t p;
    w = longint'(addr) / 2;
    r = longint'(len) + 1;
    while (r > 0) begin
      a = w % ChipWords;
      p.ca = 48'((longint'(!wr) << 47) | (64'h1 << 45) | ((a / 8) << 16) | (a % 8));
      p.wr = wr;
      if (w / ChipWords >= 2) begin
        p.cs = 1'b0; p.len = 16'(r - 1); p.last = 1'b1; p.err = 1'b1;
        exp_q.push_back(p);
        r = 0;
      end else begin
        chunk = r;
        if (longint'(maxb) + 1 < chunk) chunk = longint'(maxb) + 1;
        bnd = ChipWords - a;
        if (bnd < chunk) chunk = bnd;
        p.cs = 1'((w / ChipWords) != 0); p.len = 16'(chunk - 1);
        p.last = (chunk == r); p.err = 1'b0;
        exp_q.push_back(p);
        w += chunk;
        r -= chunk;
      end
    end
  endfunction

  // Compare process: every presented piece, stability under stall, in_ready low while busy.
  initial begin
    piece_t e, hold;
    logic stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (stall_prev) begin
          chk("hold_ca", 64'(out_ca), 64'(hold.ca));
          chk("hold_len", 64'(out_len), 64'(hold.len));
          chk("hold_cs_last", {out_cs, out_last, out_err, out_write},
              {hold.cs, hold.last, hold.err, hold.wr});
        end
        if (out_ready) begin
          stall_prev = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_piece", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("piece_ca", 64'(out_ca), 64'(e.ca));
            chk("piece_len", 64'(out_len), 64'(e.len));
            chk("piece_cs", 64'(out_cs), 64'(e.cs));
            chk("piece_flags", {out_write, out_last, out_err}, {e.wr, e.last, e.err});
          end
        end else begin
          stall_prev = 1'b1;
          hold = '{ca: out_ca, cs: out_cs, len: out_len, wr: out_write,
                   last: out_last, err: out_err};
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] addr, input logic [15:0] len, input logic wr);
    int t;
    model(addr, len, wr, mb);
    @(negedge clk);
    in_addr = addr; in_len = len; in_write = wr; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("idle_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_ca"}, 64'(out_ca), 64'd0);
    chk({tag, "_len_cs"}, {out_len, out_cs}, 64'd0);
    chk({tag, "_flags"}, {out_last, out_err, out_write}, 64'd0);
`ifdef HYPERBUS_SPLIT_STATS_EN
    chk({tag, "_stats"}, {stat_pieces, stat_splits}, 64'd0);
`endif
  endtask

  initial begin
    #3;
    chk_reset_vals("reset");

    // Pin the model against hand-computed pieces.
    model(32'h100, 16'd7, 1'b1, 16'hFFFF);
    chk("pin1_n", 64'(exp_q.size()), 64'd1);
    chk("pin1_ca", 64'(exp_q[0].ca), 64'h2000_0010_0000);
    chk("pin1_len_last", {exp_q[0].len, exp_q[0].last, exp_q[0].cs}, {16'd7, 1'b1, 1'b0});
    exp_q.delete();
    model(32'h0, 16'd99, 1'b0, 16'd31);
    chk("pin2_n", 64'(exp_q.size()), 64'd4);
    chk("pin2_lens", {exp_q[0].len, exp_q[1].len, exp_q[2].len, exp_q[3].len},
        {16'd31, 16'd31, 16'd31, 16'd3});
    chk("pin2_ca1", 64'(exp_q[1].ca), 64'hA000_0004_0000);
    chk("pin2_last", {exp_q[0].last, exp_q[1].last, exp_q[2].last, exp_q[3].last}, 64'b0001);
    exp_q.delete();
    model(32'h7F_FFF0, 16'd15, 1'b1, 16'hFFFF);
    chk("pin3_ca0", 64'(exp_q[0].ca), 64'h2007_FFFF_0000);
    chk("pin3_p1", {exp_q[1].ca, exp_q[1].cs, exp_q[1].len, exp_q[1].last},
        {48'h2000_0000_0000, 1'b1, 16'd7, 1'b1});
    exp_q.delete();
    model(32'h100_0000, 16'd3, 1'b0, 16'hFFFF);
    chk("pin4", {exp_q.size() == 1, exp_q[0].err, exp_q[0].last, exp_q[0].cs, exp_q[0].len},
        {1'b1, 1'b1, 1'b1, 1'b0, 16'd3});
    exp_q.delete();

    @(negedge clk);
    rst_n = 1'b1;

    mb = 16'hFFFF; send(32'h100, 16'd7, 1'b1);      wait_done();
    mb = 16'd31;   send(32'h0, 16'd99, 1'b0);       wait_done();
    mb = 16'hFFFF; send(32'h7F_FFF0, 16'd15, 1'b1); wait_done();
    send(32'h100_0000, 16'd3, 1'b0);                wait_done();
    send(32'h0, 16'hFFFF, 1'b1);                    wait_done();
    send(32'h7F_0000, 16'hFFFF, 1'b0);              wait_done();
    mb = 16'd0;    send(32'h6, 16'd2, 1'b1);        wait_done();
    mb = 16'd3;    send(32'h101, 16'd9, 1'b0);
    send(32'h3F_FFFC, 16'd5, 1'b1);                 wait_done();

    // Stall piece 2 of a split read for 5 cycles.
    mb = 16'd31;
    send(32'h0, 16'd99, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();

    // Asynchronous reset mid-transfer, then a fresh split.
    send(32'h0, 16'd99, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h0, 16'd99, 1'b0);
    wait_done();
`ifdef HYPERBUS_SPLIT_STATS_EN
    chk("stats_after", {stat_pieces, stat_splits}, {32'd4, 32'd1});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
